// File: rtl/rambam_pkg.sv
//----------------------------------------------------------------------
// rambam_pkg: shared types and GF(2) polynomial helpers | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package rambam_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest field element the helpers support; narrower ones are zero-extended.
  localparam int MAXN = 64;

  function automatic int num_digits(input int n, input int dig);
    return n / dig;
  endfunction

  function automatic int cnt_width(input int c);
    return $clog2(c + 1);
  endfunction

  function automatic logic [MAXN-1:0] mulx_mod(input logic [MAXN-1:0] v,
                                                input logic [MAXN-1:0] pq_low,
                                                input int              n);
    logic [MAXN-1:0] mask;
    logic [MAXN-1:0] hibit;
    logic [MAXN-1:0] r;
    mask  = ~({MAXN{1'b1}} << n);
    hibit = {{(MAXN-1){1'b0}}, 1'b1} << (n - 1);
    r     = (v << 1) & mask;
    if (|(v & hibit)) r = r ^ (pq_low & mask);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rambam_digit_step.sv
//----------------------------------------------------------------------
// rambam_digit_step: one digit of (acc*x^DIG + a*D) mod PQ | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module rambam_digit_step
  import rambam_pkg::*;
#(
  parameter int           d   = 8,
  parameter logic [8+d:0] PQ  = {1'b1, {(7+d){1'b0}}, 1'b1},
  parameter int           DIG = 1
) (
  input  logic [7+d:0]   acc,
  input  logic [7+d:0]   a,
  input  logic [DIG-1:0] dgt,
  output logic [7+d:0]   nxt
);

  localparam int N = 8 + d;

  logic [N-1:0] t;
  logic [N-1:0] p;

  // dgt[k] weights a*x^k; a is walked up one power per bit alongside the sum.
  always_comb begin
    t = acc;
    for (int k = 0; k < DIG; k++) begin
      t = N'(mulx_mod(MAXN'(t), MAXN'(PQ[N-1:0]), N));
    end
    p = a;
    for (int k = 0; k < DIG; k++) begin
      if (dgt[k]) t = t ^ p;
      p = N'(mulx_mod(MAXN'(p), MAXN'(PQ[N-1:0]), N));
    end
    nxt = t;
  end

endmodule

`default_nettype wire

// File: rtl/rambam_digit_mult.sv
//----------------------------------------------------------------------
// rambam_digit_mult: digit-serial RAMBAM multiply / MAC | rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module rambam_digit_mult
  import rambam_pkg::*;
#(
  parameter int           d   = 8,
  parameter logic [8+d:0] PQ  = {1'b1, {(7+d){1'b0}}, 1'b1},
  parameter int           DIG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic         acc_i,
  input  logic [0:7+d] p1,
  input  logic [0:7+d] p2,
  output logic         drdy_o,
  output logic         busy,
  output logic [0:7+d] out
);

  localparam int N  = 8 + d;
  localparam int C  = num_digits(N, DIG);
  localparam int CW = cnt_width(C);

  generate
    if (PQ[N] !== 1'b1) begin : g_bad_pq
      $error("rambam_digit_mult: PQ bit N must be 1");
    end
    if ((DIG < 1) || (DIG > N) || ((N % DIG) != 0)) begin : g_bad_dig
      $error("rambam_digit_mult: DIG must divide N and lie in 1..N");
    end
    if (N > MAXN) begin : g_bad_n
      $error("rambam_digit_mult: N exceeds helper width");
    end
  endgenerate

  state_t        state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [N-1:0]  nxt;

  rambam_digit_step #(
    .d   (d),
    .PQ  (PQ),
    .DIG (DIG)
  ) u_step (
    .acc (acc),
    .a   (a_r),
    .dgt (b_r[N-1 -: DIG]),
    .nxt (nxt)
  );

  // Port element 0 is the top coefficient, so a plain copy keeps bit k = x^k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
      drdy_o <= 1'b0;
      busy   <= 1'b0;
    end else begin
      drdy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_i) begin
            a_r   <= p1;
            b_r   <= p2;
            acc   <= acc_i ? out : '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= nxt;
          b_r <= b_r << DIG;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(C - 1)) begin
            out    <= nxt;
            drdy_o <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire
